csa_pipe_adder: RTL

Parametrised, pipelined carry-select adder: the successor to the fixed 64-bit, 8×8-block combinational carry-select adder. Operand width, carry-select block width and the number of blocks resolved per pipeline stage are parameters. The block adds valid/ready flow control and a signed-overflow output. It sits on the datapath between operand registers and the result consumer, and accepts one addition per cycle at full throughput.

---
 rtl/csa_pipe_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder. Each stage resolves BLOCKS_PER_STAGE blocks of BLOCK bits
// and registers the partial sum and running carry; a global stall provides valid/ready flow control.
module csa_pipe_adder #(
  parameter int WIDTH            = 64,
  parameter int BLOCK            = 8,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int GROUP  = (BLOCK * BLOCKS_PER_STAGE < 1) ? 1 : BLOCK * BLOCKS_PER_STAGE;
  localparam int STAGES = (WIDTH / GROUP < 1) ? 1 : WIDTH / GROUP;

  if (WIDTH < 1 || BLOCK < 1 || BLOCKS_PER_STAGE < 1) begin : g_bad_param
    $error("csa_pipe_adder: WIDTH, BLOCK and BLOCKS_PER_STAGE must all be >= 1");
  end else if (WIDTH % (BLOCK * BLOCKS_PER_STAGE) != 0) begin : g_bad_width
    $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK*BLOCKS_PER_STAGE");
  end

  // Stage registers
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            carry_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;
  logic                         overflow_q;

  // Next-state values; valid/a/b are simply the stage inputs forwarded
  logic [STAGES-1:0]            valid_d;
  logic [STAGES-1:0]            carry_d;
  logic [STAGES-1:0][WIDTH-1:0] a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_d;
  logic                         overflow_d;

  logic [STAGES-1:0]            carry_in;
  logic [STAGES-1:0][WIDTH-1:0] sum_in;

  logic advance;

  assign advance   = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];
  assign overflow  = overflow_q;

  // Stage 0 takes the ports; every later stage takes its predecessor's registers.
  always_comb begin
    // NOTE: every variable gets a default before any conditional/loop write, so no latch is inferred.
    valid_d  = '0;
    a_d      = '0;
    b_d      = '0;
    carry_in = '0;
    sum_in   = '0;
    valid_d[0]  = in_valid;
    a_d[0]      = a;
    b_d[0]      = b;
    carry_in[0] = c_in;
    for (int s = 1; s < STAGES; s++) begin
      valid_d[s]  = valid_q[s-1];
      a_d[s]      = a_q[s-1];
      b_d[s]      = b_q[s-1];
      carry_in[s] = carry_q[s-1];
      sum_in[s]   = sum_q[s-1];
    end
  end

  // Carry-select resolution: both candidate block sums are formed independently of the
  // incoming carry, which then ripples only through the per-block selects.
  always_comb begin
    logic [BLOCK:0] cand0;
    logic [BLOCK:0] cand1;
    logic           c;
    int             lo;
    sum_d   = sum_in;
    carry_d = '0;
    cand0   = '0;
    cand1   = '0;
    c       = 1'b0;
    lo      = 0;
    for (int s = 0; s < STAGES; s++) begin
      c = carry_in[s];
      for (int j = 0; j < BLOCKS_PER_STAGE; j++) begin
        lo    = s * GROUP + j * BLOCK;
        cand0 = {1'b0, a_d[s][lo +: BLOCK]} + {1'b0, b_d[s][lo +: BLOCK]};
        cand1 = {1'b0, a_d[s][lo +: BLOCK]} + {1'b0, b_d[s][lo +: BLOCK]} + (BLOCK+1)'(1);
        sum_d[s][lo +: BLOCK] = c ? cand1[BLOCK-1:0] : cand0[BLOCK-1:0];
        c = c ? cand1[BLOCK] : cand0[BLOCK];
      end
      carry_d[s] = c;
    end
    // Carry into the MSB is recovered inside the final block as a^b^sum at bit WIDTH-1.
    overflow_d = a_d[STAGES-1][WIDTH-1] ^ b_d[STAGES-1][WIDTH-1]
               ^ sum_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    if (rst) begin
      // NOTE: data registers are reset as well so sum/c_out/overflow read 0 out of reset.
      valid_q    <= '0;
      carry_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else if (advance) begin
      valid_q    <= valid_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
    end
  end

  // The last stage's operand copies have no consumer.
  logic unused_last_operands;
  assign unused_last_operands = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule
